// File: rtl/alu_issue_queue.sv
// alu_issue_queue: four-entry request FIFO in front of a combinational ALU,
// with a one-entry registered result stage and a sticky overflow flag.
// The head entry drives the ALU directly; the result register captures the
// ALU output when it is empty or being drained, and that capture pops the head.
module alu_issue_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4    // only 4 is supported: pointers are 2 bits
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // request side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_func,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    // ALU side
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_func,
    input  logic [DATA_WIDTH-1:0] alu_c,
    input  logic                  alu_of,
    // result side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_c,
    output logic                  out_of,
    // status
    output logic                  ovf_sticky,
    input  logic                  ovf_clear,
    output logic [2:0]            count
);

    typedef struct packed {
        logic [3:0]            func;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } req_t;

    req_t       mem [0:3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       empty;
    logic       push;
    logic       pop;

    // Full/empty come from the occupancy counter, never from pointer compare.
    assign empty    = (count == 3'd0);
    assign in_ready = (count < 3'(DEPTH)) && reset_n;
    assign push     = in_valid && in_ready;
    // Capture (and pop) whenever there is a head and the result slot is free
    // or being consumed this cycle. A push into an empty queue is not visible
    // here until the next edge, which gives the two-edge minimum latency.
    assign pop      = !empty && (!out_valid || out_ready);

    // Head entry presented to the ALU; zeros while empty so stale storage
    // is never observable.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_func = '0;
        if (!empty) begin
            alu_a    = mem[rd_ptr].a;
            alu_b    = mem[rd_ptr].b;
            alu_func = mem[rd_ptr].func;
        end
    end

    // FIFO storage: written at the tail, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{func: in_func, a: in_a, b: in_b};
    end

    // Pointers and occupancy; reset beats any push/pop on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Result register: load on capture, clear valid when drained without a
    // replacement, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_of    <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_c     <= alu_c;
            out_of    <= alu_of;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow: a capture with overflow wins over a same-edge clear.
    always_ff @(posedge clk) begin
        if (!reset_n)
            ovf_sticky <= 1'b0;
        else if (pop && alu_of)
            ovf_sticky <= 1'b1;
        else if (ovf_clear)
            ovf_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU on the alu_* ports.
module tb_alu_issue_queue;

    localparam int DW = 16;

    localparam logic [3:0] FUNC_ADD = 4'h0;
    localparam logic [3:0] FUNC_SUB = 4'h1;
    localparam logic [3:0] FUNC_AND = 4'h2;
    localparam logic [3:0] FUNC_OR  = 4'h3;
    localparam logic [3:0] FUNC_XOR = 4'h4;
    localparam logic [3:0] FUNC_NOT = 4'h5;
    localparam logic [3:0] FUNC_LLS = 4'h6;
    localparam logic [3:0] FUNC_LRS = 4'h7;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_func;
    logic [DW-1:0] in_a, in_b;
    logic [DW-1:0] alu_a, alu_b, alu_c;
    logic [3:0]    alu_func;
    logic          alu_of;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_c;
    logic          out_of;
    logic          ovf_sticky;
    logic          ovf_clear;
    logic [2:0]    count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] expq [$];

    always #5 clk = ~clk;

    alu_issue_queue #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
        .in_a(in_a), .in_b(in_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_c(alu_c), .alu_of(alu_of),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_of(out_of),
        .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear), .count(count)
    );

    // Behavioural ALU: signed overflow on ADD/SUB, shifts by b[3:0].
    always_comb begin
        alu_c  = '0;
        alu_of = 1'b0;
        case (alu_func)
            FUNC_ADD: begin
                alu_c  = alu_a + alu_b;
                alu_of = (alu_a[DW-1] == alu_b[DW-1]) && (alu_c[DW-1] != alu_a[DW-1]);
            end
            FUNC_SUB: begin
                alu_c  = alu_a - alu_b;
                alu_of = (alu_a[DW-1] != alu_b[DW-1]) && (alu_c[DW-1] != alu_a[DW-1]);
            end
            FUNC_AND: alu_c = alu_a & alu_b;
            FUNC_OR:  alu_c = alu_a | alu_b;
            FUNC_XOR: alu_c = alu_a ^ alu_b;
            FUNC_NOT: alu_c = ~alu_a;
            FUNC_LLS: alu_c = alu_a << alu_b[3:0];
            FUNC_LRS: alu_c = alu_a >> alu_b[3:0];
            default:  alu_c = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid = v;
        in_func  = f;
        in_a     = a;
        in_b     = b;
    endtask

    // Consume n results from expq (out_ready must be 1); drops in_valid once
    // the pending request is accepted.
    task automatic drain(input int n, input int budget);
        int  got = 0;
        bit  pushing;
        for (int c = 0; c < budget && got < n; c++) begin
            if (out_valid) begin
                chk("drain_c", out_c, expq.pop_front());
                got++;
            end
            pushing = in_valid && in_ready;
            if (pushing) chk("slot_count", count, 3);
            tick();
            if (pushing) in_valid = 1'b0;
        end
        chk("drain_n", got, n);
    endtask

    // Stream vectors: func, a, b, expected c.
    logic [3:0]    s_f [10] = '{FUNC_NOT, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_LLS,
                                FUNC_LRS, FUNC_ADD, FUNC_SUB, FUNC_NOT, FUNC_AND};
    logic [DW-1:0] s_a [10] = '{16'h00FF, 16'h0F0F, 16'hF000, 16'hAAAA, 16'h0001,
                                16'h8000, 16'h1234, 16'h0005, 16'h1234, 16'hFFFF};
    logic [DW-1:0] s_b [10] = '{16'h0000, 16'h00FF, 16'h000F, 16'hFFFF, 16'h0004,
                                16'h000F, 16'h1111, 16'h0007, 16'h0000, 16'h1234};
    logic [DW-1:0] s_c [10] = '{16'hFF00, 16'h000F, 16'hF00F, 16'h5555, 16'h0010,
                                16'h0001, 16'h2345, 16'hFFFE, 16'hEDCB, 16'h1234};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v, last_v, nv, idx;
        bit pushing;

        reset_n = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
        drive(1'b0, 4'h0, '0, '0);
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_out_of", out_of, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_in_ready", in_ready, 0);
        reset_n = 1'b1;
        #1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_alu", {alu_func, alu_a, alu_b}, 0);

        // Single ADD: out_valid two edges after the push.
        out_ready = 1'b1;
        drive(1'b1, FUNC_ADD, 16'h0001, 16'h0001);
        tick();
        in_valid = 1'b0;
        chk("add_count1", count, 1);
        chk("add_nv1", out_valid, 0);
        chk("add_head", {alu_func, alu_a, alu_b}, {FUNC_ADD, 16'h0001, 16'h0001});
        tick();
        chk("add_v2", out_valid, 1);
        chk("add_c", out_c, 16'h0002);
        chk("add_of", out_of, 0);
        chk("add_ovf", ovf_sticky, 0);
        chk("add_count2", count, 0);
        tick();
        chk("add_drained", out_valid, 0);

        // Overflow sets sticky, survives a clean op, clears on pulse.
        drive(1'b1, FUNC_ADD, 16'h7FFF, 16'h0005);
        tick();
        drive(1'b1, FUNC_SUB, 16'h0003, 16'h0001);
        tick();
        in_valid = 1'b0;
        chk("ovf_c", out_c, 16'h8004);
        chk("ovf_of", out_of, 1);
        chk("ovf_set", ovf_sticky, 1);
        tick();
        chk("sub_c", out_c, 16'h0002);
        chk("sub_of", out_of, 0);
        chk("ovf_hold", ovf_sticky, 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf_clr", ovf_sticky, 0);

        // Back-pressure: occupy the result slot, then fill the FIFO.
        out_ready = 1'b0;
        drive(1'b1, FUNC_ADD, 16'h0100, 16'h0001);
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_pre_v", out_valid, 1);
        expq.push_back(16'h0101);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, FUNC_ADD, 16'h1000 + 16'(k * 16), 16'(k));
            expq.push_back(16'h1000 + 16'(k * 17));
            chk("bp_in_ready", in_ready, (k < 4) ? 1 : 0);
            if (k < 4) tick();
        end
        chk("bp_full", count, 4);
        chk("bp_hold_c", out_c, 16'h0101);
        chk("bp_hold_v", out_valid, 1);
        out_ready = 1'b1;
        drain(6, 30);
        tick();
        chk("bp_empty", count, 0);

        // Streaming at full rate.
        first_v = -1; last_v = -1; nv = 0; idx = 0;
        for (int c = 0; c < 16; c++) begin
            if (idx < 10) drive(1'b1, s_f[idx], s_a[idx], s_b[idx]);
            else          in_valid = 1'b0;
            if (out_valid) begin
                chk("str_c", out_c, s_c[nv]);
                if (first_v < 0) first_v = c;
                last_v = c;
                nv++;
            end
            pushing = in_valid && in_ready;
            tick();
            if (pushing) idx++;
        end
        chk("str_first", first_v, 2);
        chk("str_last", last_v, 11);
        chk("str_n", nv, 10);

        // Mid-stream reset discards everything.
        out_ready = 1'b0;
        drive(1'b1, FUNC_ADD, 16'h7FFF, 16'h0001);
        tick();
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, FUNC_OR, 16'h0F00, 16'(k));
            tick();
        end
        chk("pre_rst_count", count, 3);
        chk("pre_rst_v", out_valid, 1);
        chk("pre_rst_ovf", ovf_sticky, 1);
        reset_n = 1'b0; out_ready = 1'b1;
        tick();
        reset_n = 1'b1; in_valid = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_v", out_valid, 0);
        chk("mid_rst_ovf", ovf_sticky, 0);
        chk("mid_rst_c", out_c, 0);
        nv = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) nv++;
            tick();
        end
        chk("mid_rst_stale", nv, 0);

        // Set beats clear on the same edge.
        drive(1'b1, FUNC_SUB, 16'h7FFF, 16'hFFFF);
        tick();
        in_valid = 1'b0;
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("sc_ovf", ovf_sticky, 1);
        chk("sc_c", out_c, 16'h8000);
        chk("sc_of", out_of, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
